// File: rtl/regfile_fwd.sv
// Parametrised integer register file: write-back source mux, same-edge write-to-read
// forwarding, read hold, and a post-reset sweep that zeroes every register.
//
// state    | meaning
// ST_CLEAR | sweep zeroes register cnt each edge; reads/writes ignored, init_busy=1
// ST_RUN   | normal write-back and synchronous reads, init_busy=0
module regfile_fwd #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [AW-1:0]         rd,
  input  logic [1:0]            WBSel,
  input  logic [XLEN-1:0]       PC,
  input  logic [XLEN-1:0]       ALU_out,
  input  logic [XLEN-1:0]       dmem_out,
  input  logic                  read_en,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic                  init_busy
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]      state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rd_val [NREAD];
  logic            wr_ok;

  always_comb begin
    unique case (WBSel)
      2'b00:   wdata = PC + XLEN'(4);
      2'b01:   wdata = ALU_out;
      default: wdata = dmem_out;
    endcase
  end

  assign wr_ok     = (state == ST_RUN) && write_enable && (rd != '0);
  assign init_busy = (state == ST_CLEAR);

  // Register 0 is never read from storage; a matching write on the same edge wins over storage.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a         = raddr[i*AW +: AW];
    assign rd_val[i] = (a == '0) ? '0 :
                       (wr_ok && (rd == a)) ? wdata : regs[a];
  end

  // Storage has no reset of its own; the sweep is what clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) regs[cnt] <= '0;
      else if (wr_ok)        regs[rd]  <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= AW'(1);
      rdata <= '0;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + AW'(1);
      if (cnt == AW'(NREGS - 1)) state <= ST_RUN;
    end else if (read_en) begin
      for (int i = 0; i < NREAD; i++) rdata[i*XLEN +: XLEN] <= rd_val[i];
    end
  end

endmodule

// File: tb/tb_regfile_fwd.sv
// Self-checking bench for regfile_fwd: directed checks with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_regfile_fwd;

  logic        clk = 1'b0;
  logic        rst, write_enable, read_en, init_busy;
  logic [4:0]  rd;
  logic [1:0]  WBSel;
  logic [31:0] PC, ALU_out, dmem_out;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  int ncmp = 0;
  int nerr = 0;
  bit done = 1'b0;

  regfile_fwd #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .rd(rd), .WBSel(WBSel),
    .PC(PC), .ALU_out(ALU_out), .dmem_out(dmem_out), .read_en(read_en),
    .raddr(raddr), .rdata(rdata), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: reads see the architectural state before the edge plus the write on that edge
  bit          model_valid = 1'b0;
  bit          m_busy;
  int          m_next;
  logic [31:0] m_regs [32];
  logic [31:0] exp_rd [2];
  logic [31:0] m_wd;
  logic [4:0]  m_a;

  always @(posedge clk) begin
    m_wd = (WBSel == 2'd0) ? PC + 32'd4 : (WBSel == 2'd1) ? ALU_out : dmem_out;
    if (rst) begin
      model_valid = 1'b1;
      m_busy      = 1'b1;
      m_next      = 1;
      exp_rd[0]   = 32'd0;
      exp_rd[1]   = 32'd0;
    end else if (model_valid) begin
      if (m_busy) begin
        m_regs[m_next] = 32'd0;
        m_next++;
        if (m_next == 32) m_busy = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          m_a = raddr[i*5 +: 5];
          if (read_en)
            exp_rd[i] = (m_a == 5'd0) ? 32'd0 :
                        (write_enable && rd == m_a) ? m_wd : m_regs[m_a];
        end
        if (write_enable && rd != 5'd0) m_regs[rd] = m_wd;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid && !done) begin
      chk("model_init_busy", {31'd0, init_busy}, {31'd0, m_busy});
      chk("model_rdata0", rdata[31:0], exp_rd[0]);
      chk("model_rdata1", rdata[63:32], exp_rd[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    write_enable = 1'b0; read_en = 1'b0; rd = '0; WBSel = '0;
    PC = '0; ALU_out = '0; dmem_out = '0; raddr = '0;
  endtask

  task automatic sweep_len(input string name);
    int n;
    for (n = 1; n <= 100; n++) begin
      tick();
      if (!init_busy) break;
    end
    chk(name, n, 31);
  endtask

  task automatic wr(input logic [4:0] a, input logic [1:0] sel,
                    input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dm);
    write_enable = 1'b1; rd = a; WBSel = sel; PC = pc; ALU_out = alu; dmem_out = dm;
    read_en = 1'b0;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    raddr = {5'd0, a}; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk(name, rdata[31:0], exp);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    chk("reset_busy", {31'd0, init_busy}, 32'd1);
    chk("reset_rdata", rdata[31:0] | rdata[63:32], 32'd0);
    rst = 1'b0;
    sweep_len("sweep_len");

    for (int k = 0; k < 16; k++) begin
      raddr = {5'(2*k + 1), 5'(2*k)}; read_en = 1'b1;
      tick();
      chk("cleared_p0", rdata[31:0], 32'd0);
      chk("cleared_p1", rdata[63:32], 32'd0);
    end
    idle();

    wr(5'd5,  2'd0, 32'h0000_0100, 32'h0, 32'h0);
    rd_chk("wb_pc4", 5'd5, 32'h0000_0104);
    wr(5'd6,  2'd0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    rd_chk("wb_pc4_wrap", 5'd6, 32'h0000_0000);
    wr(5'd8,  2'd1, 32'h0, 32'h1111_1111, 32'h9999_9999);
    rd_chk("wb_alu", 5'd8, 32'h1111_1111);
    wr(5'd10, 2'd2, 32'h0, 32'h9999_9999, 32'h2222_2222);
    rd_chk("wb_dmem10", 5'd10, 32'h2222_2222);
    wr(5'd11, 2'd3, 32'h0, 32'h9999_9999, 32'h3333_3333);
    rd_chk("wb_dmem11", 5'd11, 32'h3333_3333);

    write_enable = 1'b1; rd = 5'd7; WBSel = 2'd1; ALU_out = 32'hDEAD_BEEF;
    raddr = {5'd7, 5'd7}; read_en = 1'b1;
    tick();
    chk("fwd_p0", rdata[31:0], 32'hDEAD_BEEF);
    chk("fwd_p1", rdata[63:32], 32'hDEAD_BEEF);

    rd = 5'd0; ALU_out = 32'h1234_5678; raddr = 10'd0;
    tick();
    idle();
    chk("x0_write", rdata[31:0], 32'd0);
    rd_chk("x0_later", 5'd0, 32'd0);

    rd_chk("stall_pre", 5'd5, 32'h0000_0104);
    write_enable = 1'b1; rd = 5'd3; WBSel = 2'd1; ALU_out = 32'h55;
    raddr = {5'd0, 5'd3}; read_en = 1'b0;
    tick();
    write_enable = 1'b0;
    chk("stall_hold", rdata[31:0], 32'h0000_0104);
    rd_chk("stall_release", 5'd3, 32'h55);

    wr(5'd9, 2'd1, 32'h0, 32'hAA, 32'h0);
    rd_chk("x9_pre", 5'd9, 32'hAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    write_enable = 1'b1; rd = 5'd9; WBSel = 2'd1; ALU_out = 32'hBB;
    raddr = {5'd9, 5'd9}; read_en = 1'b1;
    repeat (10) tick();
    chk("midsweep_busy", {31'd0, init_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_len("resweep_len");
    idle();
    rd_chk("x9_cleared", 5'd9, 32'd0);

    for (int c = 0; c < 1500; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      write_enable = 1'($urandom_range(0, 1));
      rd           = 5'($urandom_range(0, 31));
      WBSel        = 2'($urandom_range(0, 3));
      PC           = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      ALU_out      = $urandom;
      dmem_out     = $urandom;
      read_en      = ($urandom_range(0, 3) != 0);
      raddr        = ($urandom_range(0, 3) == 0) ? {rd, rd} : 10'($urandom);
      tick();
    end

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_fwd.md
# regfile_fwd

Parametrised integer register file with write-back source selection, same-cycle write-to-read forwarding, a read-hold (stall) input and a post-reset clearing sweep. It sits between the decode stage (read addresses) and write-back (ALU, data memory, link address) of the RISC-V core. It is the generalised successor of the fixed 32x32, two-read-port register file.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, ≥2
- NREAD, 2, number of synchronous read ports, ≥1
- AW (localparam), $clog2(NREGS), register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- write_enable  in  1  request write of wdata to rd
- rd  in  AW  destination register address
- WBSel  in  2  write-back source: 00 = PC+4, 01 = ALU_out, 10 and 11 = dmem_out
- PC  in  XLEN  PC of the writing instruction; the block adds 4 itself
- ALU_out  in  XLEN  ALU result
- dmem_out  in  XLEN  data memory load result
- read_en  in  1  1 = update read outputs this edge, 0 = hold them (stall)
- raddr  in  NREAD*AW  read addresses; port i is bits [i*AW +: AW]
- rdata  out  NREAD*XLEN  registered read data; port i is bits [i*XLEN +: XLEN]
- init_busy  out  1  clearing sweep in progress; writes and reads are ignored

## Operation
- wdata = PC+4 (mod 2^XLEN), ALU_out, or dmem_out per WBSel. This is combinational and internal.
- Register 0 is hardwired to zero:
  - Writes to rd=0 are dropped.
  - A read of address 0 returns 0 regardless of storage contents.
- State machine, two states:
  - CLEAR: init_busy=1.
  - RUN: init_busy=0.
- Any edge with rst=1:
  - state ← CLEAR, sweep counter cnt ← 1.
  - All rdata ← 0.
  - Storage is not written.
  - Applies from any state, including mid-sweep: the sweep restarts from 1.
- CLEAR with rst=0:
  - Each edge writes 0 to register cnt, then cnt ← cnt+1.
  - On the edge that clears register NREGS-1, state ← RUN.
  - write_enable, raddr and read_en are ignored; rdata holds 0.
- RUN:
  - Write: if write_enable=1 and rd≠0, register rd ← wdata on the edge.
  - Read: if read_en=1, each port i is updated with the contents of raddr[i] as of that edge. Forwarding applies: if write_enable=1, rd≠0 and rd==raddr[i] on the same edge, rdata[i] ← wdata (new value), not the stale contents.
  - If read_en=0, rdata holds its previous value. Writes still occur while reads are held.
  - Multiple ports may read the same address. All of them receive identical data, including forwarded data.
- Before the first reset, storage contents are undefined. Simulation models register 0 as 0.

## Timing
- Read latency: 1 cycle. An address presented before edge N is visible on rdata after edge N.
- Write is visible to:
  - a read sampled on the same edge, via forwarding;
  - any later read, via storage.
- Reset timing:
  - rst sampled high at edge E0 → init_busy=1 and rdata=0 after E0.
  - rst low at edges E1..E(NREGS-1) → registers 1..NREGS-1 are cleared.
  - init_busy=0 after edge E(NREGS-1), i.e. NREGS-1 cycles after the first rst-low edge.
  - If rst stays high, cnt stays at 1 and init_busy stays 1.
- First accepted write or read: edge E(NREGS). Its read data is valid after that edge.
- Reset values of outputs: rdata = 0 on all ports, init_busy = 1.

## Test plan
- Reset sweep: with NREGS=32, pulse rst for 1 cycle → init_busy=1 for exactly 31 edges after release, then 0. Reading all 32 registers then returns 0x00000000.
- Write-back mux:
  - WBSel=00, PC=0x00000100, rd=5 → read x5 = 0x00000104.
  - WBSel=00, PC=0xFFFFFFFC → 0x00000000 (wrap).
  - WBSel=01 → ALU_out; WBSel=10 and 11 → dmem_out.
- Forwarding: write 0xDEADBEEF to x7 while raddr[0]=raddr[1]=7 on the same edge → both rdata = 0xDEADBEEF after that edge.
- x0: write_enable=1, rd=0, ALU_out=0x12345678, raddr[0]=0 on the same edge → rdata[0]=0. A later read of x0 also returns 0.
- Stall: read_en=0 while x3 is written with 0x55 and raddr[0]=3 → rdata[0] holds its old value. Raise read_en → rdata[0]=0x55 one edge later.
- Reset mid-sweep and mid-run:
  - Write x9=0xAA, assert rst, then assert rst again 10 cycles into the sweep → init_busy stays high for 31 edges after the second release.
  - Writes issued during the sweep are ignored, and x9 reads 0 afterwards.
